adder_bist_controller: RTL and testbench

//  Synthesizable on-chip exerciser for the team's combinational adders (half adder, widened adders).

---
 rtl/adder_bist_controller_pkg.sv | 20 ++
 rtl/adder_bist_controller_vector_counter.sv | 42 ++++
 rtl/adder_bist_controller.sv | 152 +++++++++++++++
 tb/tb_adder_bist_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_controller_pkg.sv
// Shared definitions for the adder BIST controller: FSM state encoding and
// sizing helpers used by the controller and its vector counter.
package adder_bist_controller_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Width of a counter that must hold values 0 .. settle-1 (at least 1 bit).
    function automatic int settle_cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/adder_bist_controller_vector_counter.sv
// Operand-pair counter for the adder BIST: walks 0 .. 2^VEC_W-1 and flags the
// last vector so the controller terminates by compare, never by wrap-around.
module adder_bist_controller_vector_counter #(
    parameter int VEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             last_o
);

    localparam logic [VEC_W-1:0] VEC_LAST = {VEC_W{1'b1}};

    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;

    // Next-count selection: clear wins over increment.
    always_comb begin
        // NOTE: default assignment first so every path assigns vec_d and no latch is inferred.
        vec_d = vec_q;
        if (clr_i) begin
            vec_d = '0;
        end else if (inc_i) begin
            vec_d = vec_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset to vector 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign vec_o  = vec_q;
    assign last_o = (vec_q == VEC_LAST);

endmodule

// File: rtl/adder_bist_controller.sv
// Built-in self-test wrapper for a combinational adder: drives every operand
// pair, waits SETTLE_CYCLES, compares {carry,sum} with a+b, counts mismatches
// (saturating), captures the first failing pair and reports pass/fail.
module adder_bist_controller
    import adder_bist_controller_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] fail_count,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    localparam int                VEC_W       = 2 * WIDTH;
    localparam int                SET_W       = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_e           state_q;
    logic [SET_W-1:0] settle_q;
    logic [WIDTH-1:0] dut_a_q;
    logic [WIDTH-1:0] dut_b_q;
    logic [WIDTH-1:0] first_fail_a_q;
    logic [WIDTH-1:0] first_fail_b_q;
    logic [ERR_W-1:0] fail_count_q;
    logic             fail_seen_q;
    logic             busy_q;
    logic             done_q;

    logic [VEC_W-1:0] vec;
    logic             vec_last;
    logic             start_accept;
    logic             vec_inc;
    logic [WIDTH:0]   expected;
    logic [WIDTH:0]   observed;
    logic             vec_match;

    // A start is only honoured when no run is in progress.
    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign vec_inc      = (state_q == ST_CHECK) && !vec_last;

    adder_bist_controller_vector_counter #(
        .VEC_W (VEC_W)
    ) u_vector_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_accept),
        .inc_i  (vec_inc),
        .vec_o  (vec),
        .last_o (vec_last)
    );

    assign expected = {1'b0, dut_a_q} + {1'b0, dut_b_q};
    assign observed = {dut_carry, dut_sum};

    // Result compare; an unknown compare falls to the default, so X/Z reads as a mismatch.
    always_comb begin
        vec_match = 1'b0;
        if (observed == expected) begin
            vec_match = 1'b1;
        end
    end

    // Run sequencer: FSM, operand drive, settle timing and result capture.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q        <= ST_IDLE;
            settle_q       <= '0;
            dut_a_q        <= '0;
            dut_b_q        <= '0;
            first_fail_a_q <= '0;
            first_fail_b_q <= '0;
            fail_count_q   <= '0;
            fail_seen_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q        <= ST_DRIVE;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        fail_count_q   <= '0;
                        fail_seen_q    <= 1'b0;
                        first_fail_a_q <= '0;
                        first_fail_b_q <= '0;
                    end
                end
                ST_DRIVE: begin
                    dut_a_q  <= vec[VEC_W-1:WIDTH];
                    dut_b_q  <= vec[WIDTH-1:0];
                    settle_q <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!vec_match) begin
                        if (fail_count_q != {ERR_W{1'b1}}) begin
                            fail_count_q <= fail_count_q + 1'b1;
                        end
                        if (!fail_seen_q) begin
                            fail_seen_q    <= 1'b1;
                            first_fail_a_q <= dut_a_q;
                            first_fail_b_q <= dut_b_q;
                        end
                    end
                    if (vec_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRIVE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_a        = dut_a_q;
    assign dut_b        = dut_b_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = done_q && (fail_count_q == '0);
    assign fail_count   = fail_count_q;
    assign first_fail_a = first_fail_a_q;
    assign first_fail_b = first_fail_b_q;

endmodule

// File: tb/tb_adder_bist_controller.sv
// Directed bench for the adder BIST controller: a 1-bit instance (SETTLE=1)
// and a 2-bit instance (SETTLE=3, 2-bit saturating fail counter), each driving
// a behavioural adder with selectable faults.
module tb_adder_bist_controller;

    logic clk;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: WIDTH=1, SETTLE_CYCLES=1, ERR_W=8
    logic       rst1, start1;
    logic [0:0] a1, b1, sum1, ffa1, ffb1;
    logic       carry1, busy1, done1, pass1;
    logic [7:0] fail1;
    int         mode1;   // 0 golden, 1 carry stuck-at-0, 2 sum inverted
    logic [1:0] r1;

    assign r1     = {1'b0, a1} + {1'b0, b1};
    assign carry1 = (mode1 == 1) ? 1'b0 : r1[1];
    assign sum1   = (mode1 == 2) ? ~r1[0] : r1[0];

    adder_bist_controller #(
        .WIDTH(1), .SETTLE_CYCLES(1), .ERR_W(8)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_sum(sum1), .dut_carry(carry1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fail1),
        .first_fail_a(ffa1), .first_fail_b(ffb1)
    );

    // Instance 2: WIDTH=2, SETTLE_CYCLES=3, ERR_W=2
    logic       rst2, start2;
    logic [1:0] a2, b2, sum2, ffa2, ffb2;
    logic       carry2, busy2, done2, pass2;
    logic [1:0] fail2;
    int         mode2;   // 0 golden, 1 carry stuck-at-0
    logic [2:0] r2;

    assign r2     = {1'b0, a2} + {1'b0, b2};
    assign carry2 = (mode2 == 1) ? 1'b0 : r2[2];
    assign sum2   = r2[1:0];

    adder_bist_controller #(
        .WIDTH(2), .SETTLE_CYCLES(3), .ERR_W(2)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_sum(sum2), .dut_carry(carry2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail2),
        .first_fail_a(ffa2), .first_fail_b(ffb2)
    );

    // Start pulse: raised at negedge, sampled at the next posedge, dropped 1ns later.
    task automatic start1_pulse();
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic start2_pulse();
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
    endtask

    // Counts cycles from the start-sampling edge until done, bounded.
    task automatic wait_done1(output int lat);
        lat = 0;
        while (!done1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_done2(output int lat);
        lat = 0;
        while (!done2 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy1, done1, pass1, fail1, ffa1, ffb1, a1, b1} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs_w1: got %h expected 0",
                     {busy1, done1, pass1, fail1, ffa1, ffb1, a1, b1});
        end
        checks++;
        if ({busy2, done2, pass2, fail2, ffa2, ffb2, a2, b2} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs_w2: got %h expected 0",
                     {busy2, done2, pass2, fail2, ffa2, ffb2, a2, b2});
        end
        @(negedge clk) rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_golden_w1();
        int lat;
        mode1 = 0;
        start1_pulse();
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL golden_busy_after_start: got busy=%b done=%b expected busy=1 done=0", busy1, done1);
        end
        wait_done1(lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL golden_latency: got %0d expected 12", lat); end
        checks++;
        if (pass1 !== 1'b1 || fail1 !== 8'd0) begin
            errors++;
            $display("FAIL golden_result: got pass=%b fail=%0d expected pass=1 fail=0", pass1, fail1);
        end
        checks++;
        if ({a1, b1} !== 2'b11 || busy1 !== 1'b0 || {ffa1, ffb1} !== 2'b00) begin
            errors++;
            $display("FAIL golden_final_state: got ab=%b busy=%b ff=%b expected ab=11 busy=0 ff=00",
                     {a1, b1}, busy1, {ffa1, ffb1});
        end
    endtask

    task automatic test_carry_stuck_w1();
        int lat;
        mode1 = 1;
        start1_pulse();
        wait_done1(lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL carry_stuck_latency: got %0d expected 12", lat); end
        checks++;
        if (fail1 !== 8'd1 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL carry_stuck_count: got fail=%0d pass=%b expected fail=1 pass=0", fail1, pass1);
        end
        checks++;
        if (ffa1 !== 1'b1 || ffb1 !== 1'b1) begin
            errors++;
            $display("FAIL carry_stuck_first: got a=%b b=%b expected a=1 b=1", ffa1, ffb1);
        end
    endtask

    task automatic test_sum_inverted_w1();
        int lat;
        mode1 = 2;
        start1_pulse();
        checks++;
        if (fail1 !== 8'd0 || {ffa1, ffb1} !== 2'b00 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL restart_clears: got fail=%0d ff=%b done=%b expected fail=0 ff=00 done=0",
                     fail1, {ffa1, ffb1}, done1);
        end
        wait_done1(lat);
        checks++;
        if (fail1 !== 8'd4 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL sum_inv_count: got fail=%0d pass=%b expected fail=4 pass=0", fail1, pass1);
        end
        checks++;
        if (ffa1 !== 1'b0 || ffb1 !== 1'b0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL sum_inv_first: got a=%b b=%b done=%b expected a=0 b=0 done=1", ffa1, ffb1, done1);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        mode1 = 0;
        start1_pulse();
        checks++;
        if (fail1 !== 8'd0) begin errors++; $display("FAIL busy_start_clear: got %0d expected 0", fail1); end
        lat = 0;
        while (!done1 && lat < 200) begin
            start1 = (lat == 5);
            @(posedge clk);
            #1;
            lat++;
        end
        start1 = 1'b0;
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL busy_start_latency: got %0d expected 12", lat); end
        checks++;
        if (pass1 !== 1'b1) begin errors++; $display("FAIL busy_start_pass: got %b expected 1", pass1); end
    endtask

    task automatic test_start_held_in_done();
        int lat;
        mode1 = 0;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1;
        wait_done1(lat);
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL held_first_latency: got %0d expected 12", lat); end
        @(posedge clk);
        #1;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL held_rerun: got done=%b busy=%b expected done=0 busy=1", done1, busy1);
        end
        start1 = 1'b0;
        wait_done1(lat);
        checks++;
        if (lat !== 12 || pass1 !== 1'b1) begin
            errors++;
            $display("FAIL held_second_run: got lat=%0d pass=%b expected lat=12 pass=1", lat, pass1);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        mode1 = 2;
        start1_pulse();
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({a1, b1} !== 2'b10 || fail1 !== 8'd2) begin
            errors++;
            $display("FAIL midrun_progress: got ab=%b fail=%0d expected ab=10 fail=2", {a1, b1}, fail1);
        end
        rst1 = 1'b1;
        #1;
        checks++;
        if ({busy1, done1, pass1, fail1, ffa1, ffb1, a1, b1} !== 15'd0) begin
            errors++;
            $display("FAIL midrun_reset_clear: got %h expected 0",
                     {busy1, done1, pass1, fail1, ffa1, ffb1, a1, b1});
        end
        @(negedge clk) rst1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: got busy=%b done=%b expected busy=0 done=0", busy1, done1);
        end
        mode1 = 0;
        start1_pulse();
        wait_done1(lat);
        checks++;
        if (lat !== 12 || pass1 !== 1'b1 || fail1 !== 8'd0) begin
            errors++;
            $display("FAIL midrun_clean_rerun: got lat=%0d pass=%b fail=%0d expected lat=12 pass=1 fail=0",
                     lat, pass1, fail1);
        end
    endtask

    task automatic test_golden_w2();
        int lat;
        mode2 = 0;
        start2_pulse();
        wait_done2(lat);
        checks++;
        if (lat !== 80) begin errors++; $display("FAIL w2_latency: got %0d expected 80", lat); end
        checks++;
        if (pass2 !== 1'b1 || fail2 !== 2'd0 || {a2, b2} !== 4'hF) begin
            errors++;
            $display("FAIL w2_golden: got pass=%b fail=%0d ab=%h expected pass=1 fail=0 ab=f",
                     pass2, fail2, {a2, b2});
        end
    endtask

    task automatic test_saturation_w2();
        int lat;
        mode2 = 1;
        start2_pulse();
        wait_done2(lat);
        checks++;
        if (lat !== 80) begin errors++; $display("FAIL w2_sat_latency: got %0d expected 80", lat); end
        checks++;
        if (fail2 !== 2'd3 || pass2 !== 1'b0) begin
            errors++;
            $display("FAIL w2_saturate: got fail=%0d pass=%b expected fail=3 pass=0", fail2, pass2);
        end
        checks++;
        if (ffa2 !== 2'd1 || ffb2 !== 2'd3) begin
            errors++;
            $display("FAIL w2_first_fail: got a=%0d b=%0d expected a=1 b=3", ffa2, ffb2);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mode1  = 0;
        mode2  = 0;
        start1 = 1'b0;
        start2 = 1'b0;
        rst1   = 1'b1;
        rst2   = 1'b1;

        test_reset();
        test_golden_w1();
        test_carry_stuck_w1();
        test_sum_inverted_w1();
        test_start_while_busy();
        test_start_held_in_done();
        test_reset_midrun();
        test_golden_w2();
        test_saturation_w2();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
